key_sched_ctrl: RTL and testbench

//  Sequencer and round-key server in front of key_sh.
//  - Accepts a 128-bit master key over a valid/ready handshake.
//  - Pulses key_sh start, waits for keys_ready with a timeout, and latches the 9x64-bit bank.
//  - Serves keys by index to the cipher round datapath, one request per cycle, 1-cycle latency.

---
 rtl/key_sched_ctrl.sv | 130 +++++++++++++
 tb/tb_key_sched_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// Sequencer and round-key server in front of key_sh: accepts a master key, runs one
// generation with timeout, latches the round-key bank and serves it with 1-cycle latency.
module key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 9,
  parameter int unsigned KEY_W      = 64,
  parameter int unsigned TIMEOUT    = 63
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mk_valid,
  input  logic [127:0]                mk_data,
  output logic                        mk_ready,
  output logic                        ks_start,
  output logic [127:0]                ks_master_key,
  input  logic [NUM_ROUNDS*KEY_W-1:0] ks_round_keys,
  input  logic                        ks_ready,
  output logic                        keys_valid,
  output logic                        busy,
  output logic                        err_timeout,
  input  logic                        rk_req,
  input  logic [3:0]                  rk_idx,
  output logic                        rk_ack,
  output logic [KEY_W-1:0]            rk_key,
  output logic                        rk_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [KEY_W-1:0]   bank [NUM_ROUNDS];
  logic               accept, capture, expire;
  logic               rd_hit;
  logic [KEY_W-1:0]   rd_key;

  always_comb begin
    state_nxt = state;
    mk_ready  = 1'b0;
    ks_start  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      S_IDLE: begin
        mk_ready = 1'b1;
        if (mk_valid) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        ks_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // ks_ready takes priority over an expiring counter
        if (ks_ready) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      ks_master_key <= '0;
      keys_valid    <= 1'b0;
      err_timeout   <= 1'b0;
      for (int unsigned i = 0; i < NUM_ROUNDS; i++) bank[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_START)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      if (accept) begin
        ks_master_key <= mk_data;
        keys_valid    <= 1'b0;
        err_timeout   <= 1'b0;
      end
      if (capture) begin
        keys_valid <= 1'b1;
        for (int unsigned i = 0; i < NUM_ROUNDS; i++)
          bank[i] <= ks_round_keys[i*KEY_W +: KEY_W];
      end
      if (expire) err_timeout <= 1'b1;
    end
  end

  // Match loop doubles as the range check, so indices past the bank never select anything
  always_comb begin
    rd_hit = 1'b0;
    rd_key = '0;
    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
      if (rk_idx == 4'(i)) begin
        rd_hit = 1'b1;
        rd_key = bank[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_ack <= 1'b0;
      rk_key <= '0;
      rk_err <= 1'b0;
    end else begin
      rk_ack <= rk_req;
      if (rk_req) begin
        if (keys_valid && rd_hit) begin
          rk_key <= rd_key;
          rk_err <= 1'b0;
        end else begin
          rk_key <= '0;
          rk_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: key_sh stub, event-scheduled reference model, vector table,
// directed corner sequences and a randomized run.
module tb_key_sched_ctrl;

  localparam int NR = 9;
  localparam int KW = 64;
  localparam int TO = 63;

  logic           clk = 1'b0;
  logic           rst;
  logic           mk_valid, mk_ready, ks_start, ks_ready;
  logic [127:0]   mk_data, ks_master_key;
  logic [NR*KW-1:0] ks_round_keys;
  logic           keys_valid, busy, err_timeout;
  logic           rk_req, rk_ack, rk_err;
  logic [3:0]     rk_idx;
  logic [KW-1:0]  rk_key;

  key_sched_ctrl #(.NUM_ROUNDS(NR), .KEY_W(KW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mk_valid(mk_valid), .mk_data(mk_data), .mk_ready(mk_ready),
    .ks_start(ks_start), .ks_master_key(ks_master_key), .ks_round_keys(ks_round_keys),
    .ks_ready(ks_ready), .keys_valid(keys_valid), .busy(busy), .err_timeout(err_timeout),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_ack(rk_ack), .rk_key(rk_key), .rk_err(rk_err)
  );

  always #5 clk = ~clk;

  // key_sh stub: ready pulse 5 cycles after start; not reset, so it can fire after a reset
  logic [KW-1:0] stub_keys [NR];
  logic          stub_en, ks_force;
  int unsigned   stub_cd = 0;
  always @(posedge clk) begin
    if (ks_start === 1'b1) stub_cd <= 5;
    else if (stub_cd != 0) stub_cd <= stub_cd - 1;
  end
  always_comb begin
    ks_round_keys = '0;
    for (int i = 0; i < NR; i++) ks_round_keys[i*KW +: KW] = stub_keys[i];
  end
  assign ks_ready = ks_force | (stub_en && stub_cd == 1);

  // Reference model: generation scheduled by age since the accept edge
  logic          m_idle, m_valid, m_err, m_ok;
  int            m_age;
  logic [KW-1:0] m_bank [NR];
  logic [KW-1:0] m_pend [NR];
  logic [127:0]  m_master;
  logic          e_ack, e_err;
  logic [KW-1:0] e_key;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("mk_ready", mk_ready, m_idle);
    chk("busy", busy, !m_idle);
    chk("ks_start", ks_start, !m_idle && m_age == 0);
    chk("keys_valid", keys_valid, m_valid);
    chk("err_timeout", err_timeout, m_err);
    chk("ks_master_key", ks_master_key, m_master);
    chk("rk_ack", rk_ack, e_ack);
    chk("rk_key", rk_key, e_key);
    chk("rk_err", rk_err, e_err);
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_ok = 1'b0; m_age = 0;
    m_master = '0; e_ack = 1'b0; e_err = 1'b0; e_key = '0;
    for (int i = 0; i < NR; i++) m_bank[i] = '0;
  endtask

  task automatic step();
    logic req, acc;
    logic [3:0] idx;
    req = rk_req; idx = rk_idx; acc = mk_valid && m_idle;
    @(posedge clk);
    if (req) begin
      e_ack = 1'b1;
      if (m_valid && idx < NR) begin e_key = m_bank[idx]; e_err = 1'b0; end
      else begin e_key = '0; e_err = 1'b1; end
    end else e_ack = 1'b0;
    if (acc) begin
      m_idle = 1'b0; m_age = 0; m_valid = 1'b0; m_err = 1'b0;
      m_master = mk_data; m_ok = stub_en; m_pend = stub_keys;
    end else if (!m_idle) begin
      m_age++;
      if (m_ok && m_age == 6) begin m_bank = m_pend; m_valid = 1'b1; m_idle = 1'b1; end
      else if (m_age == TO + 2) begin m_err = 1'b1; m_idle = 1'b1; end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #2 rst = 1'b0;
  endtask

  task automatic set_pattern(input logic [KW-1:0] base);
    for (int i = 0; i < NR; i++) stub_keys[i] = base | KW'(i);
  endtask

  task automatic offer(input logic [127:0] k, input logic en);
    mk_data = k; stub_en = en; mk_valid = 1'b1;
    step();
    mk_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!m_idle && n < budget) begin step(); n++; end
    chk("gen_done_in_budget", m_idle, 1'b1);
  endtask

  typedef struct {
    logic [3:0]    idx;
    logic          exp_err;
    logic [KW-1:0] exp_key;
  } vec_t;
  vec_t tbl [11];

  initial begin
    for (int i = 0; i < NR; i++) begin
      tbl[i].idx = 4'(i); tbl[i].exp_err = 1'b0; tbl[i].exp_key = 64'hA0A0_0000_0000_0000 | 64'(i);
    end
    tbl[9].idx  = 4'd9;  tbl[9].exp_err  = 1'b1; tbl[9].exp_key  = '0;
    tbl[10].idx = 4'd15; tbl[10].exp_err = 1'b1; tbl[10].exp_key = '0;

    rst = 1'b1; mk_valid = 1'b0; mk_data = '0; rk_req = 1'b0; rk_idx = '0;
    stub_en = 1'b0; ks_force = 1'b0;
    set_pattern(64'hA0A0_0000_0000_0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 1'b0;

    // Idle read before any key
    rk_req = 1'b1; rk_idx = 4'd0; step();
    chk("idle_read_ack", rk_ack, 1'b1);
    chk("idle_read_err", rk_err, 1'b1);
    chk("idle_read_key", rk_key, 64'h0);
    rk_req = 1'b0;

    // First key
    offer(128'h0123456789ABCDEFFEDCBA9876543210, 1'b1);
    chk("mk_latched", ks_master_key, 128'h0123456789ABCDEFFEDCBA9876543210);
    chk("start_high", ks_start, 1'b1);
    step();
    chk("start_one_cycle", ks_start, 1'b0);
    wait_idle(20);
    chk("kv_after_gen", keys_valid, 1'b1);

    // Back-to-back table reads
    for (int i = 0; i < 11; i++) begin
      rk_req = 1'b1; rk_idx = tbl[i].idx;
      step();
      chk("tbl_ack", rk_ack, 1'b1);
      chk("tbl_err", rk_err, tbl[i].exp_err);
      chk("tbl_key", rk_key, tbl[i].exp_key);
    end
    rk_req = 1'b0; step();

    // Timeout, then next key clears the sticky flag
    offer(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
    wait_idle(TO + 10);
    chk("to_err", err_timeout, 1'b1);
    chk("to_kv", keys_valid, 1'b0);
    chk("to_ready", mk_ready, 1'b1);
    offer(128'h0123456789ABCDEFFEDCBA9876543210, 1'b1);
    chk("to_cleared", err_timeout, 1'b0);
    wait_idle(20);

    // Rekey with a read on the accept edge
    set_pattern(64'hB0B0_0000_0000_0000);
    rk_req = 1'b1; rk_idx = 4'd3;
    offer('1, 1'b1);
    chk("rekey_old_key", rk_key, 64'hA0A0_0000_0000_0003);
    chk("rekey_old_err", rk_err, 1'b0);
    step();
    chk("rekey_busy_err", rk_err, 1'b1);
    wait_idle(20);
    step();
    chk("rekey_new_key", rk_key, 64'hB0B0_0000_0000_0003);
    rk_req = 1'b0;

    // Reset in WAIT; stub pulse afterwards must be ignored
    offer(128'hDEAD_BEEF, 1'b1);
    repeat (3) step();
    do_reset();
    repeat (8) step();
    chk("rst_kv_stays0", keys_valid, 1'b0);
    chk("rst_idle", mk_ready, 1'b1);

    // Stale ready level while idle
    ks_force = 1'b1; repeat (3) step(); ks_force = 1'b0;
    chk("stale_ready_ignored", keys_valid, 1'b0);

    // Randomized run
    for (int n = 0; n < 1500; n++) begin
      rk_req = 1'($urandom % 2);
      rk_idx = 4'($urandom % 16);
      if (m_idle && ($urandom % 6) == 0) begin
        for (int i = 0; i < NR; i++) stub_keys[i] = {$urandom, $urandom};
        mk_data  = {$urandom, $urandom, $urandom, $urandom};
        stub_en  = 1'(($urandom % 4) != 0);
        mk_valid = 1'b1;
      end else mk_valid = 1'b0;
      ks_force = (m_idle || m_age == 0) && (($urandom % 4) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
